// File: rtl/dither_frame_sequencer.sv
// ---------------------------------------------------------------------------
// dither_frame_sequencer
//
// Frame-level controller for the Floyd-Steinberg dithering datapath. One
// frame goes through three phases:
//   LOAD    - pixel bytes from the SPI front end are written to pixel RAM
//   COMPUTE - the pixel algorithm unit is walked across the image in raster
//             order, with a neighbour-validity mask for error diffusion
//   READOUT - the result is streamed out of pixel RAM on host request
// DONE pulses frame_done_o for one cycle, and the FSM then returns to IDLE.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i              begin a frame (only looked at in IDLE)
//   in_valid_i           one input pixel byte present this cycle
//   wr_en_o, wr_addr_o   pixel RAM write port
//   px_req_o, px_ack_i   job handshake with the pixel algorithm unit
//   px_addr_o            current pixel address, y*IMAGEX+x
//   px_mask_o            neighbour valid: [0] forward, [1] below-behind,
//                        [2] below, [3] below-forward
//   px_dir_o             scan direction, 0 = left-to-right, 1 = right-to-left
//   rd_req_i             host asks for the next output pixel
//   rd_en_o, rd_addr_o   pixel RAM read port
//   busy_o               high in every state except IDLE
//   frame_done_o         one-cycle pulse at the end of a frame
//
// Configuration macro
//   SEQ_SERPENTINE_EN    when defined, odd rows are scanned right-to-left
//                        (px_dir_o=1); otherwise every row runs left-to-right
//                        and px_dir_o is tied to 0.
// ---------------------------------------------------------------------------
module dither_frame_sequencer #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int ADJ_PIXELS       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        in_valid_i,
  output logic                        wr_en_o,
  output logic [IMAGE_ADDR_WIDTH-1:0] wr_addr_o,
  output logic                        px_req_o,
  output logic [IMAGE_ADDR_WIDTH-1:0] px_addr_o,
  output logic [ADJ_PIXELS-1:0]       px_mask_o,
  output logic                        px_dir_o,
  input  logic                        px_ack_i,
  input  logic                        rd_req_i,
  output logic                        rd_en_o,
  output logic [IMAGE_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                        busy_o,
  output logic                        frame_done_o
);

  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGEX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGEY - 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] ADDR_LAST = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, READOUT, DONE} state_e;

  state_e                      state_q, state_d;
  logic [IMAGE_ADDR_WIDTH-1:0] load_cnt_q, load_cnt_d;
  logic [IMAGE_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;

  logic                        row_dir;
  logic                        next_row_dir;
  logic                        row_end;
  logic                        below;
  logic [XW-1:0]               next_row_start;
  logic [IMAGE_ADDR_WIDTH-1:0] cur_addr;
  logic [ADJ_PIXELS-1:0]       cur_mask;

  // Serpentine scanning reverses every odd row; the direction of a row is
  // therefore just the LSB of its row index.
`ifdef SEQ_SERPENTINE_EN
  assign row_dir      = y_q[0];
  assign next_row_dir = ~y_q[0];
`else
  assign row_dir      = 1'b0;
  assign next_row_dir = 1'b0;
`endif

  assign row_end        = row_dir ? (x_q == '0) : (x_q == X_LAST);
  assign next_row_start = next_row_dir ? X_LAST : '0;
  assign below          = (y_q < Y_LAST);
  assign cur_addr       = IMAGE_ADDR_WIDTH'(y_q) * IMAGE_ADDR_WIDTH'(IMAGEX)
                        + IMAGE_ADDR_WIDTH'(x_q);

  // "Forward" and "behind" are relative to the scan direction, so the
  // column tests swap ends on right-to-left rows.
  always_comb begin
    cur_mask    = '0;
    cur_mask[2] = below;
    if (!row_dir) begin
      cur_mask[0] = (x_q < X_LAST);
      cur_mask[1] = below & (x_q != '0);
      cur_mask[3] = below & (x_q < X_LAST);
    end else begin
      cur_mask[0] = (x_q != '0);
      cur_mask[1] = below & (x_q < X_LAST);
      cur_mask[3] = below & (x_q != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      rd_cnt_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // Each counter is cleared on the transition out of its own phase, so
  // every counter is already zero when the next frame begins.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    wr_en_o      = 1'b0;
    px_req_o     = 1'b0;
    px_addr_o    = '0;
    px_mask_o    = '0;
    px_dir_o     = 1'b0;
    rd_en_o      = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_o     = 1'b0;
        load_cnt_d = '0;
        rd_cnt_d   = '0;
        x_d        = '0;
        y_d        = '0;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        wr_en_o = in_valid_i;
        if (in_valid_i) begin
          if (load_cnt_q == ADDR_LAST) begin
            load_cnt_d = '0;
            state_d    = COMPUTE;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        px_req_o  = 1'b1;
        px_addr_o = cur_addr;
        px_mask_o = cur_mask;
        px_dir_o  = row_dir;
        if (px_ack_i) begin
          if (row_end) begin
            if (y_q == Y_LAST) begin
              x_d     = '0;
              y_d     = '0;
              state_d = READOUT;
            end else begin
              x_d = next_row_start;
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = row_dir ? (x_q - 1'b1) : (x_q + 1'b1);
          end
        end
      end
      READOUT: begin
        rd_en_o = rd_req_i;
        if (rd_req_i) begin
          if (rd_cnt_q == ADDR_LAST) begin
            rd_cnt_d = '0;
            state_d  = DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        frame_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr_o = load_cnt_q;
  assign rd_addr_o = rd_cnt_q;

endmodule

// File: tb/tb_dither_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dither_frame_sequencer
//
// Directed bench for dither_frame_sequencer on a 4x4 image. A behavioural
// model (phase plus linear load/scan/read positions, with pixel coordinates
// and masks worked out arithmetically) is compared against the DUT on every
// falling edge; the stimulus process adds hand-computed literal checks.
// Works with or without SEQ_SERPENTINE_EN defined.
// ---------------------------------------------------------------------------
module tb_dither_frame_sequencer;

  localparam int IMX  = 4;
  localparam int IMY  = 4;
  localparam int SIZE = IMX * IMY;
  localparam int AW   = $clog2(SIZE);

`ifdef SEQ_SERPENTINE_EN
  localparam bit SERP    = 1'b1;
  localparam int RST_IDX = 5;
`else
  localparam bit SERP    = 1'b0;
  localparam int RST_IDX = 6;
`endif

  localparam int PH_IDLE    = 0;
  localparam int PH_LOAD    = 1;
  localparam int PH_COMPUTE = 2;
  localparam int PH_READOUT = 3;
  localparam int PH_DONE    = 4;

  logic          clk      = 1'b0;
  logic          rstN     = 1'b1;
  logic          start    = 1'b0;
  logic          inValid  = 1'b0;
  logic          pxAck    = 1'b0;
  logic          rdReq    = 1'b0;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic          pxReq;
  logic [AW-1:0] pxAddr;
  logic [3:0]    pxMask;
  logic          pxDir;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic          busy;
  logic          frameDone;

  int nVectors     = 0;
  int nMiscompares = 0;
  bit checkEn      = 1'b0;

  int mPhase = PH_IDLE;
  int mLoad  = 0;
  int mScan  = 0;
  int mRead  = 0;

  // Hand-worked scan order, masks and directions for the 4x4 image
`ifdef SEQ_SERPENTINE_EN
  int scanLit [SIZE] = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15, 14, 13, 12};
  int dirLit  [SIZE] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`else
  int scanLit [SIZE] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  int dirLit  [SIZE] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
  int maskLit [SIZE] = '{13, 15, 15, 6, 13, 15, 15, 6, 13, 15, 15, 6, 1, 1, 1, 0};
  int loadGap [SIZE] = '{0, 2, 0, 1, 0, 0, 3, 0, 1, 0, 0, 2, 0, 0, 1, 0};
  int readGap [SIZE] = '{1, 0, 0, 2, 0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0};

  dither_frame_sequencer #(
    .IMAGEX (IMX),
    .IMAGEY (IMY)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (start),
    .in_valid_i   (inValid),
    .wr_en_o      (wrEn),
    .wr_addr_o    (wrAddr),
    .px_req_o     (pxReq),
    .px_addr_o    (pxAddr),
    .px_mask_o    (pxMask),
    .px_dir_o     (pxDir),
    .px_ack_i     (pxAck),
    .rd_req_i     (rdReq),
    .rd_en_o      (rdEn),
    .rd_addr_o    (rdAddr),
    .busy_o       (busy),
    .frame_done_o (frameDone)
  );

  always #5 clk = ~clk;

  // Model helpers: the n-th pixel of the scan in row/column terms
  function automatic bit dirOf(input int idx);
    return SERP && ((idx / IMX) % 2 == 1);
  endfunction

  function automatic int xOf(input int idx);
    int k = idx % IMX;
    return dirOf(idx) ? (IMX - 1 - k) : k;
  endfunction

  function automatic int addrOf(input int idx);
    return (idx / IMX) * IMX + xOf(idx);
  endfunction

  function automatic int maskOf(input int idx);
    int  x = xOf(idx);
    int  y = idx / IMX;
    bit  bl = (y < IMY - 1);
    bit  fwd, bb, bf;
    if (!dirOf(idx)) begin
      fwd = (x < IMX - 1);
      bb  = bl && (x > 0);
      bf  = bl && (x < IMX - 1);
    end else begin
      fwd = (x > 0);
      bb  = bl && (x < IMX - 1);
      bf  = bl && (x > 0);
    end
    return {28'd0, bf, bl, bb, fwd};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic a, input logic r);
    @(posedge clk);
    #1;
    start   = s;
    inValid = v;
    pxAck   = a;
    rdReq   = r;
  endtask

  // Compare the DUT against the model every falling edge, then advance the
  // model with the inputs that the coming rising edge will see.
  always @(negedge clk) begin
    if (checkEn) begin
      if (!rstN) begin
        checkOutput("m_rst_busy", busy, 0);
        checkOutput("m_rst_wr_en", wrEn, 0);
        checkOutput("m_rst_wr_addr", wrAddr, 0);
        checkOutput("m_rst_px_req", pxReq, 0);
        checkOutput("m_rst_px_addr", pxAddr, 0);
        checkOutput("m_rst_px_mask", pxMask, 0);
        checkOutput("m_rst_px_dir", pxDir, 0);
        checkOutput("m_rst_rd_en", rdEn, 0);
        checkOutput("m_rst_rd_addr", rdAddr, 0);
        checkOutput("m_rst_frame_done", frameDone, 0);
        mPhase = PH_IDLE;
        mLoad  = 0;
        mScan  = 0;
        mRead  = 0;
      end else begin
        checkOutput("m_busy", busy, (mPhase != PH_IDLE));
        checkOutput("m_wr_en", wrEn, (mPhase == PH_LOAD) && inValid);
        checkOutput("m_px_req", pxReq, (mPhase == PH_COMPUTE));
        checkOutput("m_rd_en", rdEn, (mPhase == PH_READOUT) && rdReq);
        checkOutput("m_frame_done", frameDone, (mPhase == PH_DONE));
        if (mPhase == PH_LOAD) checkOutput("m_wr_addr", wrAddr, mLoad);
        if (mPhase == PH_READOUT) checkOutput("m_rd_addr", rdAddr, mRead);
        if (mPhase == PH_COMPUTE) begin
          checkOutput("m_px_addr", pxAddr, addrOf(mScan));
          checkOutput("m_px_mask", pxMask, maskOf(mScan));
          checkOutput("m_px_dir", pxDir, dirOf(mScan));
        end
        case (mPhase)
          PH_IDLE: if (start) mPhase = PH_LOAD;
          PH_LOAD: if (inValid) begin
            if (mLoad == SIZE - 1) begin
              mLoad  = 0;
              mPhase = PH_COMPUTE;
            end else mLoad++;
          end
          PH_COMPUTE: if (pxAck) begin
            if (mScan == SIZE - 1) begin
              mScan  = 0;
              mPhase = PH_READOUT;
            end else mScan++;
          end
          PH_READOUT: if (rdReq) begin
            if (mRead == SIZE - 1) begin
              mRead  = 0;
              mPhase = PH_DONE;
            end else mRead++;
          end
          default: mPhase = PH_IDLE;
        endcase
      end
    end
  end

  initial begin
    // Reset asserted between clock edges must clear outputs immediately
    #3;
    rstN    = 1'b0;
    checkEn = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_px_req", pxReq, 0);
    checkOutput("rst_frame_done", frameDone, 0);
    checkOutput("rst_px_mask", pxMask, 0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    // Stray strobes in IDLE are ignored
    applyStimulus(0, 1, 1, 1);
    @(negedge clk);
    checkOutput("idle_wr_en", wrEn, 0);
    checkOutput("idle_rd_en", rdEn, 0);
    checkOutput("idle_busy", busy, 0);

    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkOutput("start_cycle_busy", busy, 0);

    // Load 16 pixels with gaps; a second start mid-load is ignored
    for (int k = 0; k < SIZE; k++) begin
      for (int g = 0; g < loadGap[k]; g++) begin
        applyStimulus(0, 0, (g == 0), 0);
        @(negedge clk);
        checkOutput("load_gap_wr_en", wrEn, 0);
        checkOutput("load_gap_busy", busy, 1);
      end
      applyStimulus((k == 5), 1, 0, 0);
      @(negedge clk);
      checkOutput("load_wr_en", wrEn, 1);
      checkOutput("load_wr_addr", wrAddr, k);
      checkOutput("load_busy", busy, 1);
    end

    // Scan with ack every cycle, stalling 5 cycles at scan index 6
    for (int k = 0; k < SIZE; k++) begin
      if (k == 6) begin
        for (int s = 0; s < 5; s++) begin
          applyStimulus(0, 0, 0, 0);
          @(negedge clk);
          checkOutput("stall_px_req", pxReq, 1);
          checkOutput("stall_px_addr", pxAddr, scanLit[6]);
          checkOutput("stall_px_mask", pxMask, maskLit[6]);
        end
      end
      applyStimulus(0, 0, 1, 0);
      @(negedge clk);
      checkOutput("scan_px_req", pxReq, 1);
      checkOutput("scan_px_addr", pxAddr, scanLit[k]);
      checkOutput("scan_px_mask", pxMask, maskLit[k]);
      checkOutput("scan_px_dir", pxDir, dirLit[k]);
    end
    applyStimulus(0, 0, 1, 0);
    @(negedge clk);
    checkOutput("readout_px_req", pxReq, 0);
    checkOutput("readout_busy", busy, 1);

    // Readout with gaps; a start during the first gap is ignored
    for (int k = 0; k < SIZE; k++) begin
      for (int g = 0; g < readGap[k]; g++) begin
        applyStimulus((k == 0) && (g == 0), 0, 0, 0);
        @(negedge clk);
        checkOutput("read_gap_rd_en", rdEn, 0);
        checkOutput("read_gap_busy", busy, 1);
      end
      applyStimulus(0, 0, 0, 1);
      @(negedge clk);
      checkOutput("read_rd_en", rdEn, 1);
      checkOutput("read_rd_addr", rdAddr, k);
    end
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("done_frame_done", frameDone, 1);
    checkOutput("done_busy", busy, 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("after_done_frame_done", frameDone, 0);
    checkOutput("after_done_busy", busy, 0);

    // Second frame: reset mid-scan at pixel address 6, then restart
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < SIZE; k++) applyStimulus(0, 1, 0, 0);
    for (int k = 0; k < RST_IDX; k++) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pre_rst_px_addr", pxAddr, 6);
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_px_req", pxReq, 0);
    checkOutput("async_rst_px_addr", pxAddr, 0);
    checkOutput("async_rst_px_mask", pxMask, 0);
    checkOutput("async_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("restart_wr_en", wrEn, 1);
    checkOutput("restart_wr_addr", wrAddr, 0);
    checkOutput("restart_busy", busy, 1);
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("restart_wr_addr1", wrAddr, 1);
    applyStimulus(0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/dither_frame_sequencer.md
# dither_frame_sequencer

Frame-level controller for the Floyd-Steinberg dithering datapath. It sequences one image through three phases: load pixels from the SPI byte stream into pixel RAM, walk the pixel algorithm unit across the image in raster order with neighbour-validity masks, then stream the result out on host request. It replaces the free-running top-level control and sits between the SPI front end, the pixel RAM write/read ports and the pixel algorithm unit.

## Interface
- IMAGEX, 64, image width in pixels
- IMAGEY, 64, image height in pixels
- IMAGE_SIZE, IMAGEX*IMAGEY, pixels per frame
- IMAGE_ADDR_WIDTH, $clog2(IMAGE_SIZE), RAM address width
- ADJ_PIXELS, 4, error-diffusion neighbours (width of px_mask)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  one input pixel byte is present this cycle
- wr_en  out  1  pixel RAM write strobe
- wr_addr  out  IMAGE_ADDR_WIDTH  pixel RAM write address
- px_req  out  1  pixel job valid to the algorithm unit
- px_addr  out  IMAGE_ADDR_WIDTH  current pixel address, y*IMAGEX+x
- px_mask  out  ADJ_PIXELS  neighbour valid: [0] forward, [1] below-behind, [2] below, [3] below-forward
- px_dir  out  1  scan direction: 0 = left-to-right, 1 = right-to-left
- px_ack  in  1  algorithm unit accepts the current job
- rd_req  in  1  host requests the next output pixel
- rd_en  out  1  pixel RAM read strobe
- rd_addr  out  IMAGE_ADDR_WIDTH  output read address
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, LOAD, COMPUTE, READOUT, DONE.
- IDLE: start=1 moves to LOAD. All counters are 0.
- LOAD: wr_en = in_valid (combinational), wr_addr = load counter. The counter increments on each in_valid. in_valid with the counter at IMAGE_SIZE-1 writes the last pixel, clears the counter and moves to COMPUTE.
- COMPUTE: px_req=1. px_addr, px_mask and px_dir are driven from the registered x/y counters and stay stable until px_ack.
  - On px_ack, x advances in scan direction. At the row end, x goes to the row start and y increments.
  - px_ack on the last pixel (y=IMAGEY-1, last x of the row) moves to READOUT.
- Masks, for default left-to-right scanning:
  - forward = x<IMAGEX-1
  - below = y<IMAGEY-1
  - below-behind = below & x>0
  - below-forward = below & x<IMAGEX-1
- READOUT: rd_en = rd_req (combinational), rd_addr = read counter, which increments on each rd_req. rd_req at IMAGE_SIZE-1 moves to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Boundary rules:
  - start outside IDLE is ignored.
  - in_valid outside LOAD and rd_req outside READOUT are ignored; the corresponding strobe stays 0.
  - px_ack without px_req has no effect.
  - Address counters never exceed IMAGE_SIZE-1. There is no wrap within a frame.
  - rst_n low at any time forces IDLE immediately and clears all counters and outputs.

## Timing
- Reset values: wr_en, px_req, rd_en, busy, frame_done, px_dir = 0; wr_addr, px_addr, rd_addr = 0; px_mask = 0.
- start at cycle n: busy=1 from cycle n+1.
- Last in_valid at cycle n: px_req=1 at n+1 with px_addr=0.
- px_ack at cycle n: next px_addr is valid at n+1. Sustained throughput is one pixel per cycle.
- Last px_ack at cycle n: px_req=0 at n+1, READOUT from n+1.
- Last rd_req at cycle n: frame_done=1 at n+1, busy=0 at n+2.

## Configuration
- SEQ_SERPENTINE_EN defined:
  - Odd rows scan right-to-left with px_dir=1.
  - For those rows, forward = x>0, below-behind = below & x<IMAGEX-1, below-forward = below & x>0.
  - The last pixel is x=0 when IMAGEY is even.
- Undefined: every row scans left-to-right and px_dir is tied to 0.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; after release, busy=0.
- Load (IMAGEX=IMAGEY=4): start, then 16 in_valid with random gaps -> wr_en only on valid cycles, wr_addr 0..15 in order; px_req=1 the cycle after the 16th write with px_addr=0 and px_mask=4'b1101.
- Compute masks: ack every cycle -> px_addr 0..15 consecutively; px_mask=4'b0110 at addr 3, 4'b0001 at addr 12, 4'b0000 at addr 15; READOUT after 16 acks.
- Stall: hold px_ack=0 for 5 cycles at px_addr=6 -> px_req, px_addr and px_mask stay unchanged; the ack advances to 7 on the next cycle.
- Readout: 16 rd_req pulses -> rd_addr 0..15; frame_done high exactly one cycle after the 16th; busy=0 the cycle after that. A start during READOUT is ignored.
- Serpentine (SEQ_SERPENTINE_EN, 4x4): row 1 emits px_addr 7,6,5,4 with px_dir=1, and px_mask=4'b1101 at addr 7. A reset at px_addr=6 followed by start restarts LOAD with wr_addr=0.
